// File: rtl/count_2421.sv
// Decade counter held in the 2421 (Aiken) self-complementing code.
// Advances one digit per enabled edge, wraps 9 -> 0, and snaps any illegal code back to 0.
module count_2421 (
  input  logic       clock,
  input  logic       reset,
  input  logic       x,
  output logic [3:0] out
);

  // Code words for digits 0..9; the upper five are the bitwise complements of the lower five.
  localparam logic [3:0] CODE_D0 = 4'b0000;
  localparam logic [3:0] CODE_D1 = 4'b0001;
  localparam logic [3:0] CODE_D2 = 4'b0010;
  localparam logic [3:0] CODE_D3 = 4'b0011;
  localparam logic [3:0] CODE_D4 = 4'b0100;
  localparam logic [3:0] CODE_D5 = 4'b1011;
  localparam logic [3:0] CODE_D6 = 4'b1100;
  localparam logic [3:0] CODE_D7 = 4'b1101;
  localparam logic [3:0] CODE_D8 = 4'b1110;
  localparam logic [3:0] CODE_D9 = 4'b1111;

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic [3:0] succ;
  logic       legal;

  // Successor code; illegal or unknown state words fall through to the default.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    succ  = CODE_D0;
    legal = 1'b1;
    case (cnt_q)
      CODE_D0: succ = CODE_D1;
      CODE_D1: succ = CODE_D2;
      CODE_D2: succ = CODE_D3;
      CODE_D3: succ = CODE_D4;
      CODE_D4: succ = CODE_D5;
      CODE_D5: succ = CODE_D6;
      CODE_D6: succ = CODE_D7;
      CODE_D7: succ = CODE_D8;
      CODE_D8: succ = CODE_D9;
      CODE_D9: succ = CODE_D0;
      default: legal = 1'b0;
    endcase
  end

  // Recovery from an illegal word takes priority over the enable.
  always_comb begin
    cnt_d = cnt_q;
    if (!legal) begin
      cnt_d = CODE_D0;
    end else if (x) begin
      cnt_d = succ;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (reset) begin
      cnt_q <= CODE_D0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule

// File: tb/tb_count_2421.sv
// Directed self-checking bench for the 2421-coded decade counter.
// Covers reset, counting, enable gating, wrap, async reset and illegal-code recovery.
module tb_count_2421;

  logic       clock;
  logic       reset;
  logic       x;
  logic [3:0] out;

  int checks;
  int errors;

  logic [3:0] code_tbl [10];
  logic [3:0] obs      [10];

  count_2421 dut (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .out   (out)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  task automatic chk(input logic [3:0] observed, input logic [3:0] expected, input string tag);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Apply x for one rising edge, then sample 1 ns after it.
  task automatic tick(input logic xv);
    x = xv;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    code_tbl[0] = 4'b0000; code_tbl[1] = 4'b0001; code_tbl[2] = 4'b0010;
    code_tbl[3] = 4'b0011; code_tbl[4] = 4'b0100; code_tbl[5] = 4'b1011;
    code_tbl[6] = 4'b1100; code_tbl[7] = 4'b1101; code_tbl[8] = 4'b1110;
    code_tbl[9] = 4'b1111;
    for (int i = 0; i < 10; i++) obs[i] = 4'bxxxx;

    // Reset held from time 0, released at 50 ns.
    reset = 1'b1;
    x     = 1'b0;
    #1;
    chk(out, 4'b0000, "reset_before_edge");
    @(posedge clock);
    #1;
    chk(out, 4'b0000, "reset_at_edge");
    #29;
    chk(out, 4'b0000, "reset_at_50ns");
    reset = 1'b0;

    // Ten enabled edges walk the full code sequence back to 0000.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      chk(out, code_tbl[(i + 1) % 10], $sformatf("count_seq_%0d", i));
      obs[(i + 1) % 10] = out;
    end

    // Enable gating.
    tick(1'b1);
    chk(out, 4'b0001, "gate_advance");
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk(out, 4'b0001, $sformatf("gate_hold_%0d", i));
    end

    // Walk to digit 9, wrap, then ten more edges return to 0000.
    for (int d = 2; d <= 9; d++) begin
      tick(1'b1);
      chk(out, code_tbl[d], $sformatf("walk_d%0d", d));
    end
    tick(1'b1);
    chk(out, 4'b0000, "wrap_9_to_0");
    for (int i = 0; i < 10; i++) tick(1'b1);
    chk(out, 4'b0000, "ten_edges_mod10");

    // Async reset mid-count at 1101 (digit 7).
    for (int i = 0; i < 7; i++) tick(1'b1);
    chk(out, 4'b1101, "pre_reset_d7");
    #10;
    reset = 1'b1;
    #1;
    chk(out, 4'b0000, "async_reset_between_edges");
    tick(1'b1);
    chk(out, 4'b0000, "reset_beats_x_1");
    tick(1'b1);
    chk(out, 4'b0000, "reset_beats_x_2");
    reset = 1'b0;
    tick(1'b1);
    chk(out, 4'b0001, "post_reset_first_advance");

    // Illegal-code recovery with x low.
    x = 1'b0;
    @(negedge clock);
    force dut.cnt_q = 4'b0111;
    #1;
    release dut.cnt_q;
    tick(1'b0);
    chk(out, 4'b0000, "recover_0111");

    @(negedge clock);
    force dut.cnt_q = 4'b1010;
    #1;
    release dut.cnt_q;
    tick(1'b0);
    chk(out, 4'b0000, "recover_1010");
    tick(1'b1);
    chk(out, 4'b0001, "advance_after_recover");

    // Self-complement property on the codes the DUT actually produced.
    for (int d = 0; d < 10; d++) begin
      chk(obs[d] ^ obs[9 - d], 4'b1111, $sformatf("complement_d%0d", d));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
